// File: rtl/data_cache_emu.sv
// Data-cache emulator between the ld/st issue queue and the LS buffer; optional hit path under `DCE_HIT_EN.
// Latency: hit returns data combinationally in the issue cycle; miss returns DCE_ReadDone MISS_LATENCY cycles after issue.
// Backpressure: DCE_ReadBusy is high while a miss is in flight; the queue must hold further lw issues until it drops.
module data_cache_emu #(
    parameter int MEM_DEPTH    = 128,
    parameter int CACHE_LINES  = 8,
    parameter int MISS_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Resetb,
    input  logic        Iss_LdStReady,
    input  logic        Iss_LdStOpcode,
    input  logic [4:0]  Iss_LdStRobTag,
    input  logic [31:0] Iss_LdStAddr,
    input  logic [5:0]  Iss_LdStPhyAddr,
    input  logic        Cdb_Flush,
    input  logic [4:0]  Rob_TopPtr,
    input  logic [4:0]  Cdb_RobDepth,
    input  logic        Sb_WrEn,
    input  logic [31:0] Sb_WrAddr,
    input  logic [31:0] Sb_WrData,
    output logic        DCE_ReadBusy,
    output logic        DCE_ReadDone,
    output logic [31:0] DCE_MemData,
    output logic [4:0]  DCE_RobTag,
    output logic [5:0]  DCE_PhyAddr,
    output logic [31:0] DCE_Addr,
    output logic        DCE_Opcode
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int LINE_W = $clog2(CACHE_LINES);
    localparam int TAG_W  = IDX_W - LINE_W;
    localparam int CNT_W  = $clog2(MISS_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_rob_tag;
    logic [5:0]         r_phy;
    logic [31:0]        r_addr;
    logic [31:0]        r_mem [MEM_DEPTH];

    logic [IDX_W-1:0]   w_iss_idx;
    logic [IDX_W-1:0]   w_lat_idx;
    logic [IDX_W-1:0]   w_st_idx;
    logic               w_accept;
    logic               w_hit;
    logic [4:0]         w_age;
    logic               w_kill;
    logic               w_done_miss;
    logic               w_unused_bits;

    assign w_iss_idx = Iss_LdStAddr[IDX_W+1:2];
    assign w_lat_idx = r_addr[IDX_W+1:2];
    assign w_st_idx  = Sb_WrAddr[IDX_W+1:2];

    // Byte offset and bits above the memory index never select anything.
    assign w_unused_bits = ^{Iss_LdStAddr[31:IDX_W+2], Iss_LdStAddr[1:0],
                             Sb_WrAddr[31:IDX_W+2], Sb_WrAddr[1:0]};

    assign w_accept = Iss_LdStReady & Iss_LdStOpcode & ~r_busy;

    // Age of the in-flight lw relative to the ROB head, modulo 32; younger than the branch means killed.
    assign w_age  = r_rob_tag - Rob_TopPtr;
    assign w_kill = r_busy & Cdb_Flush & (w_age > Cdb_RobDepth);

`ifdef DCE_HIT_EN
    logic [CACHE_LINES-1:0] r_line_vld;
    logic [TAG_W-1:0]       r_line_tag [CACHE_LINES];
    logic [LINE_W-1:0]      w_iss_line;
    logic [TAG_W-1:0]       w_iss_tag;
    logic [LINE_W-1:0]      w_lat_line;
    logic [TAG_W-1:0]       w_lat_tag;

    assign w_iss_line = w_iss_idx[LINE_W-1:0];
    assign w_iss_tag  = w_iss_idx[IDX_W-1:LINE_W];
    assign w_lat_line = w_lat_idx[LINE_W-1:0];
    assign w_lat_tag  = w_lat_idx[IDX_W-1:LINE_W];
    assign w_hit      = w_accept & r_line_vld[w_iss_line] & (r_line_tag[w_iss_line] == w_iss_tag);

    // Tag storage needs no reset: the valid bits gate every use.
    always_ff @(posedge Clk) begin
        if (r_state == S_DONE && !w_kill)
            r_line_tag[w_lat_line] <= w_lat_tag;
    end
`else
    assign w_hit = 1'b0;
`endif

    // Miss FSM: latch the lw, count down the miss latency, present one DONE cycle, then release Busy.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_rob_tag <= '0;
            r_phy     <= '0;
            r_addr    <= '0;
`ifdef DCE_HIT_EN
            r_line_vld <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_hit) begin
                        r_state   <= S_MISS;
                        r_busy    <= 1'b1;
                        r_cnt     <= CNT_W'(MISS_LATENCY - 1);
                        r_rob_tag <= Iss_LdStRobTag;
                        r_phy     <= Iss_LdStPhyAddr;
                        r_addr    <= Iss_LdStAddr;
                    end
                end
                S_MISS: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_kill) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`ifdef DCE_HIT_EN
                    if (!w_kill)
                        r_line_vld[w_lat_line] <= 1'b1;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Backing store: committed stores only, write-no-allocate; reads are asynchronous so a same-cycle read sees the old word.
    always_ff @(posedge Clk) begin
        if (Sb_WrEn)
            r_mem[w_st_idx] <= Sb_WrData;
    end

    assign w_done_miss  = (r_state == S_DONE) & ~w_kill;
    assign DCE_ReadBusy = r_busy;
    assign DCE_ReadDone = w_hit | w_done_miss;
    assign DCE_MemData  = w_hit ? r_mem[w_iss_idx] : r_mem[w_lat_idx];
    assign DCE_RobTag   = w_hit ? Iss_LdStRobTag  : r_rob_tag;
    assign DCE_PhyAddr  = w_hit ? Iss_LdStPhyAddr : r_phy;
    assign DCE_Addr     = w_hit ? Iss_LdStAddr    : r_addr;
    assign DCE_Opcode   = r_busy | w_hit;

`ifndef SYNTHESIS
    a_no_lw_while_busy: assert property (@(posedge Clk) disable iff (!Resetb)
        !(Iss_LdStReady && Iss_LdStOpcode && r_busy));
`endif

endmodule

// File: tb/tb_data_cache_emu.sv
module tb_data_cache_emu;

    localparam int ML = 4;
`ifdef DCE_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic        opc = 1'b0;
    logic [4:0]  iss_tag = '0;
    logic [31:0] iss_addr = '0;
    logic [5:0]  iss_phy = '0;
    logic        flush = 1'b0;
    logic [4:0]  top_ptr = 5'd2;
    logic [4:0]  depth = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        o_busy, o_done, o_opc;
    logic [31:0] o_data, o_addr;
    logic [4:0]  o_tag;
    logic [5:0]  o_phy;

    always #5 clk = ~clk;

    data_cache_emu #(.MEM_DEPTH(128), .CACHE_LINES(8), .MISS_LATENCY(ML)) dut (
        .Clk(clk), .Resetb(rst_n),
        .Iss_LdStReady(ready), .Iss_LdStOpcode(opc), .Iss_LdStRobTag(iss_tag),
        .Iss_LdStAddr(iss_addr), .Iss_LdStPhyAddr(iss_phy),
        .Cdb_Flush(flush), .Rob_TopPtr(top_ptr), .Cdb_RobDepth(depth),
        .Sb_WrEn(wr_en), .Sb_WrAddr(wr_addr), .Sb_WrData(wr_data),
        .DCE_ReadBusy(o_busy), .DCE_ReadDone(o_done), .DCE_MemData(o_data),
        .DCE_RobTag(o_tag), .DCE_PhyAddr(o_phy), .DCE_Addr(o_addr), .DCE_Opcode(o_opc)
    );

    typedef struct {
        bit          is_ld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  tag;
        logic [5:0]  phy;
        bit          hit;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every Done must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done actual data=%h tag=%h expected none", o_data, o_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (o_data !== e.data || o_tag !== e.tag) begin
                    errors++;
                    $display("FAIL sb_result actual data=%h tag=%h expected data=%h tag=%h",
                             o_data, o_tag, e.data, e.tag);
                end
            end
        end
    end

    task automatic do_st(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Issue one lw (optionally with a same-cycle store to the same word) and check the whole transaction.
    // Rob_TopPtr is held at 2; flush_at is the cycle after issue (1..ML) carrying Cdb_Flush, 0 for none.
    task automatic do_lw(input logic [31:0] a, input logic [31:0] d, input logic [4:0] tag,
                         input logic [5:0] phy, input bit hit, input int flush_at,
                         input logic [4:0] dep, input bit st_en, input logic [31:0] st_d);
        logic [4:0] age;
        bit kill;
        age  = tag - 5'd2;
        kill = !hit && (flush_at != 0) && (age > dep);
        @(posedge clk); #1;
        ready = 1'b1; opc = 1'b1; iss_addr = a; iss_tag = tag; iss_phy = phy;
        wr_en = st_en; wr_addr = a; wr_data = st_d;
        if (!kill) sb.push_back('{data: d, tag: tag});
        @(negedge clk);
        chk("issue_busy", o_busy, 0);
        chk("issue_done", o_done, hit);
        @(posedge clk); #1;
        ready = 1'b0; wr_en = 1'b0;
        if (hit) return;
        for (int k = 1; k <= ML; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            flush = (flush_at == k); depth = dep;
            @(negedge clk);
            chk("miss_busy", o_busy, 1);
            chk("miss_done", o_done, (k == ML) && !kill);
            if (k == ML && !kill) begin
                chk("miss_phy", o_phy, phy);
                chk("miss_addr", o_addr, a);
                chk("miss_opcode", o_opc, 1);
            end
            if (kill && k == flush_at) break;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("release_busy", o_busy, 0);
        chk("release_done", o_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_tag", o_tag, 0);
        chk("rst_phy", o_phy, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_opcode", o_opc, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // is_ld, addr, data (store data or expected load data), tag, phy, hit-when-tag-array-present
        vt.push_back('{1'b0, 32'h010, 32'h11112222, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h030, 32'h33334444, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h050, 32'h55556666, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h014, 32'h77778888, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h1FC, 32'hCAFEF00D, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h034, 32'h3434ABCD, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h054, 32'h5454ABCD, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b0, 32'h074, 32'h7474ABCD, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b1, 32'h010, 32'h11112222, 5'd1,  6'd3,  1'b0});
        vt.push_back('{1'b1, 32'h010, 32'h11112222, 5'd2,  6'd4,  1'b1});
        vt.push_back('{1'b1, 32'h030, 32'h33334444, 5'd3,  6'd5,  1'b0});
        vt.push_back('{1'b1, 32'h010, 32'h11112222, 5'd4,  6'd6,  1'b0});
        vt.push_back('{1'b1, 32'h014, 32'h77778888, 5'd5,  6'd7,  1'b0});
        vt.push_back('{1'b1, 32'h014, 32'h77778888, 5'd6,  6'd8,  1'b1});
        vt.push_back('{1'b0, 32'h010, 32'hDEADBEEF, 5'd0,  6'd0,  1'b0});
        vt.push_back('{1'b1, 32'h010, 32'hDEADBEEF, 5'd7,  6'd9,  1'b1});
        vt.push_back('{1'b1, 32'h050, 32'h55556666, 5'd8,  6'd10, 1'b0});
        vt.push_back('{1'b1, 32'h210, 32'hDEADBEEF, 5'd9,  6'd11, 1'b0});
        vt.push_back('{1'b1, 32'h010, 32'hDEADBEEF, 5'd10, 6'd12, 1'b1});
        vt.push_back('{1'b1, 32'h1FC, 32'hCAFEF00D, 5'd11, 6'd13, 1'b0});
        vt.push_back('{1'b1, 32'h1FC, 32'hCAFEF00D, 5'd12, 6'd14, 1'b1});

        foreach (vt[i]) begin
            if (vt[i].is_ld)
                do_lw(vt[i].addr, vt[i].data, vt[i].tag, vt[i].phy, vt[i].hit && HIT_EN, 0, 5'd0, 1'b0, 32'h0);
            else
                do_st(vt[i].addr, vt[i].data);
        end

        // Same-cycle store and lw to one word: a hit sees the old word, a miss reads after the write.
        do_lw(32'h010, HIT_EN ? 32'hDEADBEEF : 32'h0BADF00D, 5'd20, 6'd20, HIT_EN, 0, 5'd0, 1'b1, 32'h0BADF00D);

        // A sw issue is ignored.
        @(posedge clk); #1;
        ready = 1'b1; opc = 1'b0; iss_addr = 32'h054;
        @(negedge clk);
        chk("sw_done", o_done, 0);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk("sw_busy", o_busy, 0);

        // Flush cases with Rob_TopPtr = 2.
        do_lw(32'h034, 32'h3434ABCD, 5'd7,  6'd9,  1'b0, 2,  5'd3,  1'b0, 32'h0);
        do_lw(32'h034, 32'h3434ABCD, 5'd1,  6'd10, 1'b0, 1,  5'd30, 1'b0, 32'h0);
        do_lw(32'h034, 32'h3434ABCD, 5'd8,  6'd11, 1'b0, 0,  5'd0,  1'b0, 32'h0);
        do_lw(32'h054, 32'h5454ABCD, 5'd7,  6'd12, 1'b0, 2,  5'd6,  1'b0, 32'h0);
        do_lw(32'h074, 32'h7474ABCD, 5'd7,  6'd13, 1'b0, 3,  5'd5,  1'b0, 32'h0);
        do_lw(32'h034, 32'h3434ABCD, 5'd7,  6'd14, 1'b0, ML, 5'd3,  1'b0, 32'h0);
        do_lw(32'h034, 32'h3434ABCD, 5'd9,  6'd15, 1'b0, 0,  5'd0,  1'b0, 32'h0);
        do_lw(32'h034, 32'h3434ABCD, 5'd10, 6'd16, HIT_EN, 0, 5'd0, 1'b0, 32'h0);

        // Reset in the middle of a miss.
        @(posedge clk); #1;
        ready = 1'b1; opc = 1'b1; iss_addr = 32'h054; iss_tag = 5'd3; iss_phy = 6'd1;
        @(negedge clk);
        chk("rstm_issue_done", o_done, 0);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        chk("rstm_pre_busy", o_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstm_async_busy", o_busy, 0);
        chk("rstm_async_done", o_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < ML + 2; k++) begin
            @(negedge clk);
            chk("rstm_post_busy", o_busy, 0);
            chk("rstm_post_done", o_done, 0);
        end
        do_lw(32'h010, 32'h0BADF00D, 5'd4, 6'd17, 1'b0, 0, 5'd0, 1'b0, 32'h0);
        do_lw(32'h010, 32'h0BADF00D, 5'd5, 6'd18, HIT_EN, 0, 5'd0, 1'b0, 32'h0);
        do_lw(32'h034, 32'h3434ABCD, 5'd6, 6'd19, 1'b0, 0, 5'd0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
